// File: rtl/uart_tx_frame_gen.sv
// UART frame serialiser: start, DATA_WIDTH data bits LSB first, optional parity, 1-2 stop bits.
// Define UART_TX_BREAK_EN to build the line-break generator (BREAK_BITS low periods plus one mark period).
module uart_tx_frame_gen #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned BREAK_BITS = 12
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Data_Valid,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [DIV_W-1:0]      Baud_Div,
    input  logic                  Break_Req,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_TX_BREAK_EN
        , S_BREAK
`endif
    } state_t;

    state_t                state;
    logic [DIV_W-1:0]      div_cnt;
    logic [DIV_W-1:0]      div_rld;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bit;
    logic                  par_en_q;
    logic                  stop2_q;
    logic                  stop_left;

    // Divider 0 behaves as 1, so the reload value saturates at zero.
    logic [DIV_W-1:0] div_m1_c;
    logic             div_done_c;
    assign div_m1_c   = (Baud_Div == '0) ? '0 : Baud_Div - DIV_W'(1);
    assign div_done_c = (div_cnt == '0);

`ifdef UART_TX_BREAK_EN
    localparam int unsigned BRK_W = $clog2(BREAK_BITS + 1);
    logic [BRK_W-1:0] brk_cnt;
`else
    localparam int unsigned UNUSED_BREAK_BITS = BREAK_BITS;
    logic unused_break_req;
    assign unused_break_req = Break_Req;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
            div_cnt   <= '0;
            div_rld   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            stop_left <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_cnt   <= '0;
`endif
        end else if (state == S_IDLE) begin
`ifdef UART_TX_BREAK_EN
            if (Break_Req) begin
                state   <= S_BREAK;
                TX_OUT  <= 1'b0;
                busy    <= 1'b1;
                div_cnt <= div_m1_c;
                div_rld <= div_m1_c;
                brk_cnt <= BRK_W'(BREAK_BITS);
            end else
`endif
            if (Data_Valid) begin
                state    <= S_START;
                TX_OUT   <= 1'b0;
                busy     <= 1'b1;
                div_cnt  <= div_m1_c;
                div_rld  <= div_m1_c;
                shreg    <= P_DATA;
                par_bit  <= (^P_DATA) ^ PAR_TYP;
                par_en_q <= PAR_EN;
                stop2_q  <= STOP2;
            end
        end else if (!div_done_c) begin
            div_cnt <= div_cnt - DIV_W'(1);
        end else begin
            // End of a bit period: reload the divider and present the next bit.
            div_cnt <= div_rld;
            case (state)
                S_START: begin
                    state   <= S_DATA;
                    TX_OUT  <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_idx <= '0;
                end
                S_DATA: begin
                    if (bit_idx == LAST_IDX) begin
                        if (par_en_q) begin
                            state  <= S_PARITY;
                            TX_OUT <= par_bit;
                        end else begin
                            state     <= S_STOP;
                            TX_OUT    <= 1'b1;
                            stop_left <= stop2_q;
                        end
                    end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                        TX_OUT  <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
                S_PARITY: begin
                    state     <= S_STOP;
                    TX_OUT    <= 1'b1;
                    stop_left <= stop2_q;
                end
                S_STOP: begin
                    if (stop_left) begin
                        stop_left <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
`ifdef UART_TX_BREAK_EN
                // brk_cnt counts remaining low periods; the period at zero is the mark.
                S_BREAK: begin
                    if (brk_cnt == BRK_W'(1)) begin
                        TX_OUT  <= 1'b1;
                        brk_cnt <= brk_cnt - BRK_W'(1);
                    end else if (brk_cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        brk_cnt <= brk_cnt - BRK_W'(1);
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Self-checking bench for uart_tx_frame_gen: per-cycle {TX_OUT,busy} scoreboard driven from a vector table.
module tb_uart_tx_frame_gen;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       dv8 = 1'b0;
    logic       dv5 = 1'b0;
    logic [7:0] p_data8 = '0;
    logic [4:0] p_data5 = '0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       stop2 = 1'b0;
    logic [15:0] baud_div = '0;
    logic       brk = 1'b0;
    logic       brk5 = 1'b0;
    logic       tx8, busy8, tx5, busy5;

    always #5 CLK = ~CLK;

    uart_tx_frame_gen #(.DATA_WIDTH(8)) dut8 (
        .CLK(CLK), .RST(RST), .Data_Valid(dv8), .P_DATA(p_data8),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .Baud_Div(baud_div),
        .Break_Req(brk), .TX_OUT(tx8), .busy(busy8)
    );

    uart_tx_frame_gen #(.DATA_WIDTH(5)) dut5 (
        .CLK(CLK), .RST(RST), .Data_Valid(dv5), .P_DATA(p_data5),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .Baud_Div(baud_div),
        .Break_Req(brk5), .TX_OUT(tx5), .busy(busy5)
    );

    typedef struct {
        logic [7:0]  data;
        bit          w5;
        bit          pe;
        bit          pt;
        bit          s2;
        logic [15:0] div;
        bit          exp_par;
        int          exp_len;
    } vec_t;

    vec_t       vecs[7];
    logic [1:0] sb[$];
    int         n_cmp = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected {TX_OUT,busy} per cycle, followed by one idle cycle.
    task automatic push_frame(input vec_t v);
        int w = v.w5 ? 5 : 8;
        int d = (v.div == 0) ? 1 : int'(v.div);
        for (int k = 0; k < d; k++) sb.push_back(2'b01);
        for (int i = 0; i < w; i++)
            for (int k = 0; k < d; k++) sb.push_back({v.data[i], 1'b1});
        if (v.pe)
            for (int k = 0; k < d; k++) sb.push_back({v.exp_par, 1'b1});
        for (int k = 0; k < d * (v.s2 ? 2 : 1); k++) sb.push_back(2'b11);
        sb.push_back(2'b10);
    endtask

    // Drain the scoreboard one cycle at a time; inputs are disturbed after acceptance.
    task automatic check_q(input bit sel, input int drop_at, input bit b2b, output int busy_cnt);
        logic [1:0] got, exp;
        int i = 0;
        busy_cnt = 0;
        while (sb.size() > 0) begin
            @(negedge CLK);
            got = sel ? {tx5, busy5} : {tx8, busy8};
            exp = sb.pop_front();
            chk($sformatf("%s_cyc%0d", sel ? "w5" : "w8", i), int'(got), int'(exp));
            if (got[0]) busy_cnt++;
            if (i == 0) begin
                if (b2b) p_data8 = 8'hC3;
                else begin
                    p_data8  = ~p_data8;
                    p_data5  = ~p_data5;
                    par_typ  = ~par_typ;
                    baud_div = baud_div + 16'd3;
                end
            end
            if (i == drop_at) begin
                dv8 = 1'b0;
                dv5 = 1'b0;
                brk = 1'b0;
            end
            i++;
        end
    endtask

    task automatic apply(input vec_t v);
        int bc;
        @(negedge CLK);
        p_data8  = v.data;
        p_data5  = v.data[4:0];
        par_en   = v.pe;
        par_typ  = v.pt;
        stop2    = v.s2;
        baud_div = v.div;
        if (v.w5) dv5 = 1'b1;
        else dv8 = 1'b1;
        push_frame(v);
        check_q(v.w5, 0, 1'b0, bc);
        chk("busy_len", bc, v.exp_len);
    endtask

    initial begin
        int   bc;
        vec_t v;
        vecs[0] = '{data: 8'hA5, w5: 0, pe: 1, pt: 0, s2: 0, div: 16'd4, exp_par: 0, exp_len: 44};
        vecs[1] = '{data: 8'hA5, w5: 0, pe: 1, pt: 1, s2: 0, div: 16'd4, exp_par: 1, exp_len: 44};
        vecs[2] = '{data: 8'hA5, w5: 0, pe: 0, pt: 0, s2: 1, div: 16'd0, exp_par: 0, exp_len: 11};
        vecs[3] = '{data: 8'h00, w5: 0, pe: 1, pt: 0, s2: 1, div: 16'd3, exp_par: 0, exp_len: 36};
        vecs[4] = '{data: 8'hFF, w5: 0, pe: 1, pt: 1, s2: 0, div: 16'd1, exp_par: 1, exp_len: 11};
        vecs[5] = '{data: 8'h01, w5: 0, pe: 1, pt: 0, s2: 0, div: 16'd2, exp_par: 1, exp_len: 22};
        vecs[6] = '{data: 8'h13, w5: 1, pe: 1, pt: 0, s2: 0, div: 16'd2, exp_par: 1, exp_len: 16};

        repeat (2) @(negedge CLK);
        chk("rst_tx8", int'(tx8), 1);
        chk("rst_busy8", int'(busy8), 0);
        chk("rst_tx5", int'(tx5), 1);
        chk("rst_busy5", int'(busy5), 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        for (int n = 0; n < 6; n++) apply(vecs[n]);

        // Back-to-back frames with Data_Valid held: exactly one idle cycle between them.
        @(negedge CLK);
        p_data8 = 8'h3C; par_en = 0; par_typ = 0; stop2 = 0; baud_div = 16'd2; dv8 = 1'b1;
        v = '{data: 8'h3C, w5: 0, pe: 0, pt: 0, s2: 0, div: 16'd2, exp_par: 0, exp_len: 20};
        push_frame(v);
        v.data = 8'hC3;
        push_frame(v);
        check_q(1'b0, 21, 1'b1, bc);
        chk("b2b_busy_len", bc, 40);

        // Asynchronous reset in the middle of the data bits.
        @(negedge CLK);
        p_data8 = 8'hA5; par_en = 1; par_typ = 0; stop2 = 0; baud_div = 16'd4; dv8 = 1'b1;
        @(negedge CLK);
        dv8 = 1'b0;
        repeat (10) @(negedge CLK);
        chk("pre_rst_busy", int'(busy8), 1);
        #2 RST = 1'b1;
        #1;
        chk("midrst_tx", int'(tx8), 1);
        chk("midrst_busy", int'(busy8), 0);
        @(negedge CLK);
        RST = 1'b0;
        apply(vecs[0]);

        apply(vecs[6]);

`ifdef UART_TX_BREAK_EN
        // Break wins over Data_Valid: 12*3 low cycles, 3 mark cycles, data not sent.
        @(negedge CLK);
        p_data8 = 8'hA5; par_en = 1; stop2 = 0; baud_div = 16'd3; dv8 = 1'b1; brk = 1'b1;
        for (int k = 0; k < 36; k++) sb.push_back(2'b01);
        for (int k = 0; k < 3; k++) sb.push_back(2'b11);
        sb.push_back(2'b10);
        check_q(1'b0, 0, 1'b0, bc);
        chk("break_busy_len", bc, 39);
`else
        // Without the break option Break_Req has no effect on a normal frame.
        brk = 1'b1;
        apply(vecs[0]);
`endif

        repeat (3) @(negedge CLK);
        chk("final_idle_tx", int'(tx8), 1);
        chk("final_idle_busy", int'(busy8), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_gen.md
# uart_tx_frame_gen

Parametrised successor to the existing fixed 8-bit UART transmitter. Serialises one word per handshake into a UART frame with a configurable data width, optional even/odd parity, 1 or 2 stop bits and a runtime baud divider, so the TX path no longer needs a dedicated baud-rate clock. Sits between the system-side register or FIFO logic and the TX pad, and runs entirely in the system clock domain.

## Interface
- DATA_WIDTH, 8: data bits per frame, legal range 5..9.
- DIV_W, 16: width of the baud divider input.
- BREAK_BITS, 12: break length in bit periods; only used with UART_TX_BREAK_EN.
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- Data_Valid  input  1  request to send P_DATA.
- P_DATA  input  DATA_WIDTH  word to transmit, sent LSB first.
- PAR_EN  input  1  1 = parity bit present.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- STOP2  input  1  1 = two stop bits.
- Baud_Div  input  DIV_W  bit period in CLK cycles; 0 is treated as 1.
- Break_Req  input  1  break request; ignored unless UART_TX_BREAK_EN is defined.
- TX_OUT  output  1  registered serial line output; idles high.
- busy  output  1  frame or break in progress.

## Operation
- Reset: TX_OUT=1, busy=0, FSM in IDLE, all counters cleared. Reset asserted mid-frame aborts the frame immediately; the line returns high asynchronously.
- Accept: on a rising edge with busy=0 and Data_Valid=1, the block captures P_DATA, PAR_EN, PAR_TYP, STOP2 and Baud_Div. Later changes to these inputs do not affect the frame in flight.
- Data_Valid is ignored while busy=1. There is no queueing.
- FSM states: IDLE -> START -> DATA -> PARITY (only if PAR_EN) -> STOP -> IDLE. BREAK is entered from IDLE only.
- START drives 0. DATA drives the captured bits LSB first; the bit index runs 0..DATA_WIDTH-1.
- PARITY drives the XOR of the data bits, inverted when PAR_TYP=1. Parity is computed from the captured word.
- STOP drives 1 for 1 or 2 bit periods, per STOP2.
- Each state holds for Baud_Div cycles. A divider counter counts from Baud_Div-1 down to 0 and advances the bit or state on 0.

## Timing
- Latency: the start bit appears on TX_OUT in the cycle after the accepting edge. busy rises in that same cycle.
- busy stays high for exactly N*D cycles, where N = 1 + DATA_WIDTH + PAR_EN + 1 + STOP2 and D = max(Baud_Div, 1).
- busy falls in the cycle after the last stop-bit cycle. TX_OUT is 1 in that cycle.
- Back-to-back frames with Data_Valid held high have exactly one idle cycle (TX_OUT=1, busy=0) between the last stop bit and the next start bit.
- If Data_Valid and Break_Req are both high in IDLE, the break wins when UART_TX_BREAK_EN is defined.
- TX_OUT comes straight from a flop, so there is no combinational path from any input to TX_OUT.

## Configuration
- UART_TX_BREAK_EN defined:
  - Break_Req=1 in IDLE enters BREAK.
  - TX_OUT=0 for BREAK_BITS*D cycles, then 1 for one bit period (mark), with busy=1 throughout.
  - The FSM then returns to IDLE.
- UART_TX_BREAK_EN undefined: the BREAK state and its counter are not built, and Break_Req is unused.

## Test plan
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, STOP2=0, Baud_Div=4 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles; busy high for 44 cycles.
- Same word with PAR_TYP=1 -> parity bit is 1. Same word with PAR_EN=0, STOP2=1, Baud_Div=0 -> 11 bits of 1 cycle each, ending with two 1s.
- Data_Valid held high with 0x3C then 0xC3, Baud_Div=2 -> two complete frames with exactly one idle cycle between them. P_DATA changes mid-frame do not corrupt the first frame.
- RST pulsed during the DATA state -> TX_OUT=1 and busy=0 immediately. The next Data_Valid produces a clean full frame.
- DATA_WIDTH=5, P_DATA=5'h13, even parity -> bits 1,1,0,0,1 then parity 1, with correct busy length.
- With UART_TX_BREAK_EN, Break_Req and Data_Valid both high, Baud_Div=3 -> TX_OUT low for 36 cycles, then high for 3, busy high for 39 cycles; the data is not sent.
